nios_system_sw_in: RTL and testbench
====================================

// Module: nios_system_sw_in
// PURPOSE
//   Avalon-MM slave input port: the read-side counterpart of the LED output PIO.
//   Samples WIDTH board inputs (switches/keys) into the clk domain.
//   Latches rising edges per bit and raises a maskable level interrupt to the Nios II.
//   Sits on the system interconnect next to the output PIOs. Zero-wait-state access.
// PARAMETERS
//   WIDTH            18   number of input bits (1..32)
//   DEBOUNCE_CYCLES  16   consecutive stable clocks before a bit is accepted (used only with DEBOUNCE_EN)
// PORTS
//   clk         in   1      system clock
//   reset       in   1      synchronous, active-high reset
//   address     in   2      register select
//   chipselect  in   1      slave select
//   write_n     in   1      active-low write strobe
//   writedata   in   32     write data
//   readdata    out  32     read data, combinational from address; bits [31:WIDTH] always 0
//   in_port     in   WIDTH  asynchronous board inputs
//   irq         out  1      level interrupt to CPU
// BEHAVIOUR
//   Register map:
//     addr 0  DATA     RO  = stable[WIDTH-1:0]; writes ignored
//     addr 1  --       reads 0; writes ignored
//     addr 2  IRQMASK  RW  per-bit interrupt enable
//     addr 3  EDGECAP  RW1C; read = captured edges; write 1 clears that bit, write 0 keeps it
//   Write strobe: wr = chipselect & ~write_n. Reads have no side effects.
//   Synchronizer: 2-FF chain per bit, in_port -> s1 -> sync.
//   stable:
//     without debounce: stable <= sync
//     with debounce: see CONFIGURATION
//   Edge detect: prev <= stable; edge = stable & ~prev (rising only).
//   EDGECAP update, per bit i, in priority order:
//     1) edge[i] = 1 -> set
//     2) clear write with writedata[i] = 1 -> clear
//     3) otherwise hold
//   Same-cycle edge and clear on the same bit: set wins, so no edge is lost.
//   irq = |(EDGECAP & IRQMASK), decoded combinationally from registers.
//   Latency, no debounce:
//     in_port change -> DATA: 3 clocks
//     in_port rise -> EDGECAP bit and irq: 4 clocks
//   Unmasking a bit with EDGECAP already set asserts irq the cycle after the IRQMASK write.
//   Reset (sync, active-high): s1, sync, stable, prev, IRQMASK, EDGECAP and all debounce counters go to 0.
//     irq = 0 and readdata = 0 during reset.
//     Reset mid-debounce discards the partial count.
//     An input already high at reset release is captured as a rising edge 4 clocks later.
// CONFIGURATION
//   Macro NIOS_SW_IN_DEBOUNCE_EN.
//   Defined: each bit has a counter of width $clog2(DEBOUNCE_CYCLES+1).
//     Counter clears whenever sync[i] == stable[i].
//     Otherwise it increments; on reaching DEBOUNCE_CYCLES, stable[i] <= sync[i] and the counter clears.
//     A glitch shorter than DEBOUNCE_CYCLES clocks never reaches DATA or EDGECAP.
//     Debounce adds DEBOUNCE_CYCLES clocks of latency.
//   Undefined: no counters; stable <= sync; DEBOUNCE_CYCLES unused.
// TESTING
//   1) Reset, in_port = 0, then in_port = 18'h00005 -> DATA reads 32'h5 3 clocks later; readdata[31:18] = 0.
//   2) IRQMASK = 1, in_port bit0 0->1 -> EDGECAP = 1 and irq = 1 at +4 clocks;
//      write EDGECAP 32'h1 -> irq = 0 next cycle.
//   3) EDGECAP bit2 set, write 32'h1 -> bit2 stays set;
//      rising edge on bit3 in the same cycle as a clear of bit3 -> bit3 remains 1.
//   4) EDGECAP = 18'h3FFFF, IRQMASK = 0 -> irq = 0;
//      write IRQMASK 32'h20000 -> irq = 1 next cycle; write addr 0/1 -> no register change.
//   5) DEBOUNCE_EN, DEBOUNCE_CYCLES = 16: bit0 high for 10 clocks -> DATA stays 0, no edge;
//      high for 20 clocks -> DATA bit0 = 1 at 2+16+1 clocks.
//   6) Assert reset with edges pending and a debounce in progress -> all registers 0, irq = 0;
//      input held high across release -> edge captured 4 clocks after release.

Source files
------------

// File: rtl/nios_system_sw_in.sv
// nios_system_sw_in: Avalon-MM input PIO for board switches/keys.
// Synchronises WIDTH asynchronous inputs, latches per-bit rising edges into
// an RW1C capture register and raises a maskable level interrupt.
// Optional per-bit debounce filter is enabled by defining NIOS_SW_IN_DEBOUNCE_EN.
//
// Bus handshake: zero-wait-state slave. A write takes effect on the clock edge
// where chipselect=1 and write_n=0; readdata is a pure function of address and
// register state, and reads never change state.
module nios_system_sw_in #(
  parameter int WIDTH           = 18,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  logic             wr;
  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] irqmask_q;
  logic [WIDTH-1:0] irqmask_d;
  logic [WIDTH-1:0] edgecap_q;
  logic [WIDTH-1:0] edgecap_d;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr_mask;
  logic [31:0]      data_ext;
  logic [31:0]      mask_ext;
  logic [31:0]      cap_ext;
  logic             unused_wdata;

  // Upper write-data bits beyond WIDTH carry no register state.
  assign unused_wdata = ^writedata;

  assign wr = chipselect & ~write_n;

  // Two-flop synchroniser per input bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= '0;
      sync_q <= '0;
    end else begin
      s1_q   <= in_port;
      sync_q <= s1_q;
    end
  end

`ifdef NIOS_SW_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q [WIDTH];

  // Per-bit debounce: accept a new level only after it has differed from the
  // accepted level for DEBOUNCE_CYCLES consecutive clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          stable_q[i] <= sync_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end
`else
  // Without debounce the accepted level is simply the synchronised input.
  always_ff @(posedge clk) begin
    if (reset) stable_q <= '0;
    else       stable_q <= sync_q;
  end
`endif

  // Rising-edge detection against the previous accepted level.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= stable_q;
  end

  assign rise = stable_q & ~prev_q;

  // Next-state for IRQMASK and EDGECAP; a new edge beats a same-cycle clear.
  always_comb begin
    irqmask_d = irqmask_q;
    clr_mask  = '0;
    if (wr && (address == ADDR_IRQMASK)) irqmask_d = writedata[WIDTH-1:0];
    if (wr && (address == ADDR_EDGECAP)) clr_mask  = writedata[WIDTH-1:0];
    edgecap_d = rise | (edgecap_q & ~clr_mask);
  end

  // Software-visible register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  // Zero-extend the WIDTH-bit registers onto the 32-bit bus.
  always_comb begin
    data_ext              = '0;
    mask_ext              = '0;
    cap_ext               = '0;
    data_ext[WIDTH-1:0]   = stable_q;
    mask_ext[WIDTH-1:0]   = irqmask_q;
    cap_ext[WIDTH-1:0]    = edgecap_q;
  end

  // Read mux; held at zero while reset is asserted.
  always_comb begin
    readdata = '0;
    if (!reset) begin
      case (address)
        ADDR_DATA:    readdata = data_ext;
        ADDR_IRQMASK: readdata = mask_ext;
        ADDR_EDGECAP: readdata = cap_ext;
        default:      readdata = '0;
      endcase
    end
  end

  assign irq = ~reset & (|(edgecap_q & irqmask_q));

endmodule

// File: tb/tb_nios_system_sw_in.sv
// Directed testbench for nios_system_sw_in.
module tb_nios_system_sw_in;

  localparam int WIDTH = 18;
`ifdef NIOS_SW_IN_DEBOUNCE_EN
  localparam int DLAT = 3 + 16;
`else
  localparam int DLAT = 3;
`endif

  logic             clk;
  logic             reset;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int checks;
  int errors;

  nios_system_sw_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  // Driver tasks; all start and end aligned to a falling edge.
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1; in_port = '0;
    address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    wait_clks(3);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %0b exp 0", irq); end
    reset = 1'b0;
    bus_read(2'd0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", v); end
    bus_read(2'd2, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_mask got %h exp 0", v); end
    bus_read(2'd3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL reset_cap got %h exp 0", v); end
  endtask

  task automatic test_data_latency;
    logic [31:0] v;
    @(negedge clk);
    in_port = 18'h00005;
    wait_clks(DLAT - 1);
    bus_read(2'd0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL data_early got %h exp 0", v); end
    wait_clks(1);
    bus_read(2'd0, v); checks++;
    if (v !== 32'h5) begin errors++; $display("FAIL data_latency got %h exp 5", v); end
    wait_clks(1);
    bus_read(2'd3, v); checks++;
    if (v !== 32'h5) begin errors++; $display("FAIL data_edges got %h exp 5", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL data_irq_masked got %0b exp 0", irq); end
  endtask

  task automatic test_irq;
    logic [31:0] v;
    bus_write(2'd3, 32'h3FFFF);
    in_port = '0;
    wait_clks(DLAT + 1);
    bus_write(2'd2, 32'h1);
    in_port = 18'h1;
    wait_clks(DLAT);
    bus_read(2'd3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL irq_cap_early got %h exp 0", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early got %0b exp 0", irq); end
    wait_clks(1);
    bus_read(2'd3, v); checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL irq_cap got %h exp 1", v); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %0b exp 1", irq); end
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %0b exp 0", irq); end
    bus_read(2'd3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL irq_cap_clear got %h exp 0", v); end
  endtask

  task automatic test_rw1c;
    logic [31:0] v;
    in_port = 18'h5;
    wait_clks(DLAT + 1);
    bus_read(2'd3, v); checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL rw1c_bit2 got %h exp 4", v); end
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, v); checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL rw1c_keep got %h exp 4", v); end
    // Bit3 rise lands on the same clock edge as the write clearing bit3.
    in_port = 18'hD;
    wait_clks(DLAT - 1);
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, v); checks++;
    if (v !== 32'hC) begin errors++; $display("FAIL rw1c_set_wins got %h exp c", v); end
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, v); checks++;
    if (v !== 32'h4) begin errors++; $display("FAIL rw1c_clear got %h exp 4", v); end
  endtask

  task automatic test_mask_and_map;
    logic [31:0] v;
    bus_write(2'd2, 32'h0);
    in_port = '0;
    wait_clks(DLAT + 1);
    in_port = 18'h3FFFF;
    wait_clks(DLAT + 1);
    bus_read(2'd3, v); checks++;
    if (v !== 32'h3FFFF) begin errors++; $display("FAIL map_cap_all got %h exp 3ffff", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL map_irq_masked got %0b exp 0", irq); end
    bus_write(2'd2, 32'h20000);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL map_irq_top got %0b exp 1", irq); end
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read(2'd1, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL map_addr1 got %h exp 0", v); end
    bus_read(2'd2, v); checks++;
    if (v !== 32'h20000) begin errors++; $display("FAIL map_mask_kept got %h exp 20000", v); end
    bus_read(2'd3, v); checks++;
    if (v !== 32'h3FFFF) begin errors++; $display("FAIL map_cap_kept got %h exp 3ffff", v); end
    bus_read(2'd0, v); checks++;
    if (v !== 32'h3FFFF) begin errors++; $display("FAIL map_data got %h exp 3ffff", v); end
    // write_n low without chipselect must not clear anything
    @(negedge clk);
    address = 2'd3; chipselect = 1'b0; write_n = 1'b0; writedata = 32'hFFFFFFFF;
    @(negedge clk);
    write_n = 1'b1; writedata = '0;
    bus_read(2'd3, v); checks++;
    if (v !== 32'h3FFFF) begin errors++; $display("FAIL map_no_cs got %h exp 3ffff", v); end
    bus_write(2'd2, 32'hFFFFFFFF);
    bus_read(2'd2, v); checks++;
    if (v !== 32'h3FFFF) begin errors++; $display("FAIL map_mask_width got %h exp 3ffff", v); end
  endtask

`ifdef NIOS_SW_IN_DEBOUNCE_EN
  task automatic test_debounce;
    logic [31:0] v;
    in_port = '0;
    wait_clks(DLAT + 2);
    bus_write(2'd3, 32'h3FFFF);
    in_port = 18'h1;
    wait_clks(10);
    in_port = '0;
    wait_clks(25);
    bus_read(2'd0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL deb_glitch_data got %h exp 0", v); end
    bus_read(2'd3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL deb_glitch_cap got %h exp 0", v); end
    in_port = 18'h1;
    wait_clks(18);
    bus_read(2'd0, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL deb_early got %h exp 0", v); end
    wait_clks(1);
    bus_read(2'd0, v); checks++;
    if (v !== 32'h1) begin errors++; $display("FAIL deb_accept got %h exp 1", v); end
    in_port = 18'h3FFFF;
    wait_clks(DLAT + 1);
  endtask
`endif

  task automatic test_reset_midflight;
    logic [31:0] v;
    // Edges are pending and irq is high going in; in_port stays 3FFFF.
    @(negedge clk);
    reset = 1'b1;
    bus_read(2'd3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_readdata got %h exp 0", v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %0b exp 0", irq); end
    wait_clks(2);
    reset = 1'b0;
    bus_read(2'd2, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_mask got %h exp 0", v); end
    bus_read(2'd3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_cap got %h exp 0", v); end
    wait_clks(DLAT);
    bus_read(2'd0, v); checks++;
    if (v !== 32'h3FFFF) begin errors++; $display("FAIL rst_data got %h exp 3ffff", v); end
    bus_read(2'd3, v); checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL rst_cap_early got %h exp 0", v); end
    wait_clks(1);
    bus_read(2'd3, v); checks++;
    if (v !== 32'h3FFFF) begin errors++; $display("FAIL rst_cap_edge got %h exp 3ffff", v); end
  endtask

  // Test sequence and final report
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_data_latency();
    test_irq();
    test_rw1c();
    test_mask_and_map();
`ifdef NIOS_SW_IN_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
